// File: rtl/mac_se_video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// mac_se_video_timing_gen_if : synchronous frame-buffer read port
// Rev 1.0
// ============================================================================
interface mac_se_video_timing_gen_if #(
   parameter int ADDR_W = 14,
   parameter int WORD_W = 16
);
   logic              fb_rd_en;
   logic [ADDR_W-1:0] fb_rd_addr;
   logic [WORD_W-1:0] fb_rd_data;

   modport master (output fb_rd_en, output fb_rd_addr, input fb_rd_data);
   modport slave  (input fb_rd_en, input fb_rd_addr, output fb_rd_data);
endinterface
`default_nettype wire

// File: rtl/mac_se_video_timing_gen.sv
`default_nettype none
// ============================================================================
// mac_se_video_timing_gen : Mac SE raster timing generator and pixel serializer
// Rev 1.0
// ============================================================================
module mac_se_video_timing_gen #(
   parameter int H_ACTIVE     = 512,
   parameter int H_TOTAL      = 704,
   parameter int H_SYNC_START = 526,
   parameter int H_SYNC_LEN   = 176,
   parameter int V_ACTIVE     = 342,
   parameter int V_TOTAL      = 370,
   parameter int V_SYNC_START = 342,
   parameter int V_SYNC_LEN   = 4,
   parameter bit SYNC_ACT_LOW = 1'b1,
   parameter bit INVERT_DATA  = 1'b0,
   parameter int WORD_W       = 16,
   parameter int ADDR_W       = 14
) (
   input  wire logic                 mac_se_clk_in,
   input  wire logic                 reset,
   input  wire logic                 test_mode,
   input  wire logic [2:0]           pattern_sel,
   mac_se_video_timing_gen_if.master fb,
   output logic                      mac_se_hsync,
   output logic                      mac_se_vsync,
   output logic                      mac_se_data,
   output logic                      frame_start,
   output logic [3:0]                active_mode
);
   localparam int c_h_w   = $clog2(H_TOTAL + 1);
   localparam int c_v_w   = $clog2(V_TOTAL + 1);
   localparam int c_bit_w = $clog2(WORD_W);

   localparam logic [c_h_w-1:0] c_h_last     = c_h_w'(H_TOTAL - 1);
   localparam logic [c_h_w-1:0] c_h_act      = c_h_w'(H_ACTIVE);
   localparam logic [c_h_w-1:0] c_h_act_last = c_h_w'(H_ACTIVE - 1);
   localparam logic [c_h_w-1:0] c_hs_start   = c_h_w'(H_SYNC_START);
   localparam logic [c_h_w-1:0] c_hs_end     = c_h_w'(H_SYNC_START + H_SYNC_LEN);
   localparam logic [c_v_w-1:0] c_v_last     = c_v_w'(V_TOTAL - 1);
   localparam logic [c_v_w-1:0] c_v_act      = c_v_w'(V_ACTIVE);
   localparam logic [c_v_w-1:0] c_v_act_last = c_v_w'(V_ACTIVE - 1);
   localparam logic [c_v_w-1:0] c_vs_start   = c_v_w'(V_SYNC_START);
   localparam logic [c_v_w-1:0] c_vs_end     = c_v_w'(V_SYNC_START + V_SYNC_LEN);

   logic [c_h_w-1:0]  h_q, h_d;
   logic [c_v_w-1:0]  v_q, v_d;
   logic              origin, active0, fetch0, hs0, vs0, pat0;
   logic [3:0]        mode0, mode_q;
   logic [ADDR_W-1:0] addr_cnt_q, fb_rd_addr_q;
   logic              fb_rd_en_q;
   logic              hs1_q, vs1_q, act1_q, test1_q, pix1_q, fs1_q;
   logic              hsync_q, vsync_q, act2_q, test2_q, pix2_q, fs2_q, load2_q;
   logic [3:0]        active_mode_q;
   logic [WORD_W-1:0] shift_q;
   logic              fb_bit;

   always_comb begin
      h_d = h_q + c_h_w'(1);
      v_d = v_q;
      if (h_q == c_h_last) begin
         h_d = '0;
         v_d = (v_q == c_v_last) ? '0 : v_q + c_v_w'(1);
      end
   end

   assign origin  = (h_q == '0) && (v_q == '0);
   assign active0 = (h_q < c_h_act) && (v_q < c_v_act);
   assign fetch0  = active0 && (h_q[c_bit_w-1:0] == '0);
   assign hs0     = (h_q >= c_hs_start) && (h_q < c_hs_end);
   assign vs0     = (v_q >= c_vs_start) && (v_q < c_vs_end);
   // The mode used for pixel (0,0) must be the one being latched right now.
   assign mode0   = origin ? {test_mode, pattern_sel} : mode_q;

   always_comb begin
      pat0 = 1'b0;
      case (mode0[2:0])
         3'd0:    pat0 = 1'b1;
         3'd1:    pat0 = h_q[0] ^ v_q[0];
         3'd2:    pat0 = h_q[3];
         3'd3:    pat0 = (h_q == '0) || (h_q == c_h_act_last) ||
                         (v_q == '0) || (v_q == c_v_act_last);
         3'd4:    pat0 = v_q[3];
         default: pat0 = 1'b0;
      endcase
   end

   // Stage 0: raster counters and frame-start mode latch.
   always_ff @(posedge mac_se_clk_in) begin
      if (reset) begin
         h_q    <= '0;
         v_q    <= '0;
         mode_q <= '0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         mode_q <= mode0;
      end
   end

   // Stage 1: fetch request and registered timing/pattern decode.
   always_ff @(posedge mac_se_clk_in) begin
      if (reset) begin
         fb_rd_en_q   <= 1'b0;
         fb_rd_addr_q <= '0;
         addr_cnt_q   <= '0;
         hs1_q        <= 1'b0;
         vs1_q        <= 1'b0;
         act1_q       <= 1'b0;
         test1_q      <= 1'b0;
         pix1_q       <= 1'b0;
         fs1_q        <= 1'b0;
      end else begin
         fb_rd_en_q <= fetch0;
         if (fetch0) begin
            fb_rd_addr_q <= origin ? '0 : addr_cnt_q;
            addr_cnt_q   <= (origin ? '0 : addr_cnt_q) + ADDR_W'(1);
         end
         hs1_q   <= hs0;
         vs1_q   <= vs0;
         act1_q  <= active0;
         test1_q <= mode0[3];
         pix1_q  <= pat0;
         fs1_q   <= origin;
      end
   end

   // Stage 2: output registers; read data arrives alongside load2_q.
   always_ff @(posedge mac_se_clk_in) begin
      if (reset) begin
         hsync_q       <= SYNC_ACT_LOW;
         vsync_q       <= SYNC_ACT_LOW;
         act2_q        <= 1'b0;
         test2_q       <= 1'b0;
         pix2_q        <= 1'b0;
         fs2_q         <= 1'b0;
         load2_q       <= 1'b0;
         active_mode_q <= '0;
         shift_q       <= '0;
      end else begin
         hsync_q       <= hs1_q ^ SYNC_ACT_LOW;
         vsync_q       <= vs1_q ^ SYNC_ACT_LOW;
         act2_q        <= act1_q;
         test2_q       <= test1_q;
         pix2_q        <= pix1_q;
         fs2_q         <= fs1_q;
         load2_q       <= fb_rd_en_q;
         active_mode_q <= mode_q;
         shift_q       <= load2_q ? {fb.fb_rd_data[WORD_W-2:0], 1'b0}
                                  : {shift_q[WORD_W-2:0], 1'b0};
      end
   end

   // The word's MSB is shown straight from the read port on its arrival cycle.
   assign fb_bit         = load2_q ? fb.fb_rd_data[WORD_W-1] : shift_q[WORD_W-1];
   assign fb.fb_rd_en    = fb_rd_en_q;
   assign fb.fb_rd_addr  = fb_rd_addr_q;
   assign mac_se_hsync   = hsync_q;
   assign mac_se_vsync   = vsync_q;
   assign mac_se_data    = (act2_q & (test2_q ? pix2_q : fb_bit)) ^ INVERT_DATA;
   assign frame_start    = fs2_q;
   assign active_mode    = active_mode_q;
endmodule
`default_nettype wire

// File: tb/tb_mac_se_video_timing_gen.sv
`default_nettype none
// tb_mac_se_video_timing_gen : randomized self-checking bench on a reduced raster
// with a frame-arithmetic reference model.
module tb_mac_se_video_timing_gen;
   localparam int HA = 32, HT = 48, HSS = 36, HSL = 6;
   localparam int VA = 12, VT = 16, VSS = 12, VSL = 2;
   localparam int W = 8, AW = 14;
   localparam int FRAME = HT * VT;
   localparam int WORDS = VA * HA / W;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       test_mode = 1'b0;
   logic [2:0] pattern_sel = 3'd0;
   logic       hsync, vsync, data, fstart;
   logic [3:0] amode;

   int checks = 0;
   int passes = 0;
   int n = 0;
   logic [3:0] mode_hist [0:255];

   mac_se_video_timing_gen_if #(.ADDR_W(AW), .WORD_W(W)) fb_if ();

   mac_se_video_timing_gen #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
      .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL),
      .SYNC_ACT_LOW(1'b1), .INVERT_DATA(1'b0), .WORD_W(W), .ADDR_W(AW)
   ) dut (
      .mac_se_clk_in (clk),
      .reset         (reset),
      .test_mode     (test_mode),
      .pattern_sel   (pattern_sel),
      .fb            (fb_if),
      .mac_se_hsync  (hsync),
      .mac_se_vsync  (vsync),
      .mac_se_data   (data),
      .frame_start   (fstart),
      .active_mode   (amode)
   );

   always #5 clk = ~clk;

   // Frame buffer: word content equals its address; garbage when not read.
   always @(posedge clk)
      fb_if.fb_rd_data <= fb_if.fb_rd_en ? fb_if.fb_rd_addr[W-1:0] : W'($urandom);

   // Cycle index since reset release, and the mode seen at each frame origin.
   always @(posedge clk) begin
      if (reset) n <= 0;
      else begin
         if (n % FRAME == 0) mode_hist[(n / FRAME) % 256] <= {test_mode, pattern_sel};
         n <= n + 1;
      end
   end

   typedef struct packed {
      logic          hs, vs, fs, dat, en;
      logic [AW-1:0] addr;
      logic [3:0]    mode;
   } exp_t;

   function automatic logic pattern(input logic [2:0] sel, input int x, input int y);
      case (sel)
         3'd0:    return 1'b1;
         3'd1:    return (x % 2) != (y % 2);
         3'd2:    return (x / 8) % 2 == 1;
         3'd3:    return x == 0 || x == HA - 1 || y == 0 || y == VA - 1;
         3'd4:    return (y / 8) % 2 == 1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic exp_t model(input int cyc);
      exp_t e;
      int p, h, v, word;
      logic [3:0] m;
      e = '0;
      e.hs = 1'b1;
      e.vs = 1'b1;
      if (cyc >= 1) begin
         p = (cyc - 1) % FRAME; h = p % HT; v = p / HT;
         if (h < HA && v < VA && h % W == 0) begin
            e.en = 1'b1;
            e.addr = AW'((v * HA + h) / W);
         end
      end
      if (cyc >= 2) begin
         p = cyc - 2;
         m = mode_hist[(p / FRAME) % 256];
         h = (p % FRAME) % HT; v = (p % FRAME) / HT;
         e.hs = !(h >= HSS && h < HSS + HSL);
         e.vs = !(v >= VSS && v < VSS + VSL);
         e.fs = (h == 0 && v == 0);
         e.mode = m;
         if (h < HA && v < VA) begin
            if (m[3]) e.dat = pattern(m[2:0], h, v);
            else begin
               word = (v * HA + h) / W;
               e.dat = word[W - 1 - (h % W)];
            end
         end
      end
      return e;
   endfunction

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (hsync !== 1'b1) $display("FAIL reset_hsync got=%b exp=1", hsync); else passes++;
         checks++; if (vsync !== 1'b1) $display("FAIL reset_vsync got=%b exp=1", vsync); else passes++;
         checks++; if (data !== 1'b0) $display("FAIL reset_data got=%b exp=0", data); else passes++;
         checks++; if (fstart !== 1'b0) $display("FAIL reset_fs got=%b exp=0", fstart); else passes++;
         checks++; if (fb_if.fb_rd_en !== 1'b0) $display("FAIL reset_en got=%b exp=0", fb_if.fb_rd_en); else passes++;
         checks++; if (fb_if.fb_rd_addr !== '0) $display("FAIL reset_addr got=%0d exp=0", fb_if.fb_rd_addr); else passes++;
         checks++; if (amode !== 4'd0) $display("FAIL reset_mode got=%0d exp=0", amode); else passes++;
      end
   endtask

   task automatic test_startup();
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         if (i > 0) @(negedge clk);
         checks++;
         if (fstart !== (i == 2)) $display("FAIL startup_fs cyc=%0d got=%b exp=%b", i, fstart, i == 2);
         else passes++;
         checks++;
         if (fb_if.fb_rd_en !== (i == 1)) $display("FAIL startup_en cyc=%0d got=%b exp=%b", i, fb_if.fb_rd_en, i == 1);
         else passes++;
      end
   endtask

   task automatic test_sync();
      exp_t e;
      int hs_low = 0, vs_low = 0, fs_cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
         @(negedge clk);
         e = model(n);
         checks++; if (hsync !== e.hs) $display("FAIL sync_hsync n=%0d got=%b exp=%b", n, hsync, e.hs); else passes++;
         checks++; if (vsync !== e.vs) $display("FAIL sync_vsync n=%0d got=%b exp=%b", n, vsync, e.vs); else passes++;
         if (hsync === 1'b0) hs_low++;
         if (vsync === 1'b0) vs_low++;
         if (fstart === 1'b1) fs_cnt++;
         {test_mode, pattern_sel} = 4'($urandom);
      end
      checks++; if (hs_low != VT * HSL) $display("FAIL sync_hs_total got=%0d exp=%0d", hs_low, VT * HSL); else passes++;
      checks++; if (vs_low != VSL * HT) $display("FAIL sync_vs_total got=%0d exp=%0d", vs_low, VSL * HT); else passes++;
      checks++; if (fs_cnt != 1) $display("FAIL sync_fs_count got=%0d exp=1", fs_cnt); else passes++;
   endtask

   task automatic test_fetch();
      exp_t e;
      int fetches = 0, max_addr = 0, prev = -1;
      test_mode = 1'b0;
      pattern_sel = 3'($urandom);
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         e = model(n);
         checks++;
         if (fb_if.fb_rd_en !== e.en) $display("FAIL fetch_en n=%0d got=%b exp=%b", n, fb_if.fb_rd_en, e.en);
         else passes++;
         if (e.en) begin
            checks++;
            if (fb_if.fb_rd_addr !== e.addr) $display("FAIL fetch_addr n=%0d got=%0d exp=%0d", n, fb_if.fb_rd_addr, e.addr);
            else passes++;
         end
         checks++; if (data !== e.dat) $display("FAIL fetch_data n=%0d got=%b exp=%b", n, data, e.dat); else passes++;
         if (fb_if.fb_rd_en === 1'b1) begin
            if (i < FRAME) fetches++;
            if (int'(fb_if.fb_rd_addr) > max_addr) max_addr = int'(fb_if.fb_rd_addr);
            if (prev == WORDS - 1) begin
               checks++;
               if (fb_if.fb_rd_addr !== '0) $display("FAIL fetch_wrap got=%0d exp=0", fb_if.fb_rd_addr);
               else passes++;
            end
            prev = int'(fb_if.fb_rd_addr);
         end
      end
      checks++; if (fetches != WORDS) $display("FAIL fetch_count got=%0d exp=%0d", fetches, WORDS); else passes++;
      checks++; if (max_addr != WORDS - 1) $display("FAIL fetch_max got=%0d exp=%0d", max_addr, WORDS - 1); else passes++;
   endtask

   task automatic test_patterns();
      exp_t e;
      int r, sel, g;
      r = int'($urandom_range(0, 7));
      g = 0;
      while (n % FRAME != FRAME - 1 && g < 2 * FRAME) begin @(negedge clk); g++; end
      for (int k = 0; k < 8; k++) begin
         sel = (k * 3 + r) % 8;
         test_mode = 1'b1;
         pattern_sel = 3'(sel);
         for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            e = model(n);
            checks++; if (data !== e.dat) $display("FAIL pat_data sel=%0d n=%0d got=%b exp=%b", sel, n, data, e.dat); else passes++;
            checks++; if (amode !== e.mode) $display("FAIL pat_mode n=%0d got=%0d exp=%0d", n, amode, e.mode); else passes++;
            checks++; if (fstart !== e.fs) $display("FAIL pat_fs n=%0d got=%b exp=%b", n, fstart, e.fs); else passes++;
            if (n % FRAME > 10 && n % FRAME < FRAME - 10 && $urandom_range(0, 15) == 0)
               {test_mode, pattern_sel} = 4'($urandom);
         end
      end
   endtask

   task automatic test_mode_switch();
      exp_t e;
      int g = 0, p, fs_seen = 0;
      logic [3:0] prev_mode;
      while (n % FRAME != FRAME - 1 && g < 2 * FRAME) begin @(negedge clk); g++; end
      test_mode = 1'b1;
      pattern_sel = 3'd1;
      prev_mode = amode;
      for (int i = 0; i < 2 * FRAME; i++) begin
         @(negedge clk);
         e = model(n);
         p = (n - 2) % FRAME;
         checks++; if (data !== e.dat) $display("FAIL sw_data n=%0d got=%b exp=%b", n, data, e.dat); else passes++;
         if (fs_seen == 1 && (p == 0 || p == 1 || p == HT || p == HA + 3)) begin
            checks++;
            if (data !== (p == 1 || p == HT)) $display("FAIL sw_checker p=%0d got=%b exp=%b", p, data, p == 1 || p == HT);
            else passes++;
         end
         if (fstart === 1'b1) begin
            fs_seen++;
            checks++;
            if (amode !== (fs_seen == 1 ? 4'h9 : 4'hA)) $display("FAIL sw_mode_at_fs got=%0h exp=%0h", amode, fs_seen == 1 ? 4'h9 : 4'hA);
            else passes++;
            if (fs_seen == 2) begin
               checks++;
               if (prev_mode !== 4'h9) $display("FAIL sw_mode_before_fs got=%0h exp=9", prev_mode); else passes++;
            end
         end
         prev_mode = amode;
         if (n % FRAME == 5 * HT) pattern_sel = 3'd2;
      end
      checks++; if (fs_seen != 2) $display("FAIL sw_fs_count got=%0d exp=2", fs_seen); else passes++;
   endtask

   task automatic test_mid_reset(input int hc, input int vc);
      exp_t e;
      int g = 0;
      while (n % FRAME != vc * HT + hc && g < 2 * FRAME) begin @(negedge clk); g++; end
      checks++;
      if (n % FRAME != vc * HT + hc) $display("FAIL mid_reset_reach got=%0d exp=%0d", n % FRAME, vc * HT + hc);
      else passes++;
      reset = 1'b1;
      @(negedge clk);
      checks++; if (hsync !== 1'b1) $display("FAIL mid_hsync got=%b exp=1", hsync); else passes++;
      checks++; if (vsync !== 1'b1) $display("FAIL mid_vsync got=%b exp=1", vsync); else passes++;
      checks++; if (data !== 1'b0) $display("FAIL mid_data got=%b exp=0", data); else passes++;
      checks++; if (fb_if.fb_rd_en !== 1'b0) $display("FAIL mid_en got=%b exp=0", fb_if.fb_rd_en); else passes++;
      checks++; if (fb_if.fb_rd_addr !== '0) $display("FAIL mid_addr got=%0d exp=0", fb_if.fb_rd_addr); else passes++;
      checks++; if (amode !== 4'd0) $display("FAIL mid_mode got=%0d exp=0", amode); else passes++;
      reset = 1'b0;
      for (int i = 0; i < FRAME / 2; i++) begin
         if (i > 0) @(negedge clk);
         e = model(n);
         checks++; if (fstart !== (i == 2)) $display("FAIL mid_restart_fs cyc=%0d got=%b exp=%b", i, fstart, i == 2); else passes++;
         checks++; if (fb_if.fb_rd_en !== e.en) $display("FAIL mid_restart_en n=%0d got=%b exp=%b", n, fb_if.fb_rd_en, e.en); else passes++;
         checks++; if (data !== e.dat) $display("FAIL mid_restart_data n=%0d got=%b exp=%b", n, data, e.dat); else passes++;
         checks++; if (hsync !== e.hs) $display("FAIL mid_restart_hsync n=%0d got=%b exp=%b", n, hsync, e.hs); else passes++;
      end
   endtask

   initial begin
      test_reset();
      test_startup();
      test_sync();
      test_fetch();
      test_patterns();
      test_mode_switch();
      test_mid_reset(24, 6);
      test_mid_reset(40, 13);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
`default_nettype wire
